// File: rtl/johnson_phase_decoder_if.sv
// Bus between a Johnson sequence source and the phase decoder: sampled code in,
// decoded phase and health status out.
interface johnson_phase_decoder_if #(
    parameter int REV_W = 8
);
    logic [3:0]       cnt_in;
    logic             err_clr;
    logic [7:0]       phase_oh;
    logic [2:0]       phase_idx;
    logic             code_ok;
    logic             seq_err;
    logic             err_sticky;
    logic             locked;
    logic             wrap;
    logic [REV_W-1:0] rev_cnt;

    modport master (
        output cnt_in, err_clr,
        input  phase_oh, phase_idx, code_ok, seq_err, err_sticky, locked, wrap, rev_cnt
    );

    modport slave (
        input  cnt_in, err_clr,
        output phase_oh, phase_idx, code_ok, seq_err, err_sticky, locked, wrap, rev_cnt
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Decodes an 8-state Johnson counter code into one-hot/binary phase, checks code
// and step legality, tracks lock and counts full revolutions.
module johnson_phase_decoder #(
    parameter int LOCK_CNT = 8,
    parameter int REV_W    = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    johnson_phase_decoder_if.slave   bus
);
    localparam int LW = $clog2(LOCK_CNT + 1);

    logic             dec_ok;
    logic [2:0]       dec_idx;

    logic [7:0]       phase_oh_q,   phase_oh_d;
    logic [2:0]       phase_idx_q,  phase_idx_d;
    logic             code_ok_q,    code_ok_d;
    logic             seq_err_q,    seq_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic             locked_q,     locked_d;
    logic             wrap_q,       wrap_d;
    logic [REV_W-1:0] rev_cnt_q,    rev_cnt_d;
    logic             prev_ok_q,    prev_ok_d;
    logic [2:0]       prev_idx_q,   prev_idx_d;
    logic [LW-1:0]    lock_cnt_q,   lock_cnt_d;

    always_comb begin
        dec_ok  = 1'b1;
        dec_idx = 3'd0;
        case (bus.cnt_in)
            4'h0:    dec_idx = 3'd0;
            4'h8:    dec_idx = 3'd1;
            4'hC:    dec_idx = 3'd2;
            4'hE:    dec_idx = 3'd3;
            4'hF:    dec_idx = 3'd4;
            4'h7:    dec_idx = 3'd5;
            4'h3:    dec_idx = 3'd6;
            4'h1:    dec_idx = 3'd7;
            default: dec_ok  = 1'b0;
        endcase
    end

    always_comb begin
        code_ok_d   = dec_ok;
        phase_idx_d = dec_ok ? dec_idx : 3'd0;
        phase_oh_d  = dec_ok ? (8'd1 << dec_idx) : 8'd0;
        seq_err_d   = 1'b0;
        wrap_d      = 1'b0;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        prev_ok_d   = prev_ok_q;
        prev_idx_d  = prev_idx_q;
        rev_cnt_d   = rev_cnt_q;

        if (!dec_ok) begin
            seq_err_d  = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            prev_ok_d  = 1'b0;
        end else if (!prev_ok_q) begin
            // First legal sample after reset or an illegal code: no step to judge.
            prev_ok_d  = 1'b1;
            prev_idx_d = dec_idx;
        end else begin
            prev_idx_d = dec_idx;
            if (dec_idx == prev_idx_q + 3'd1) begin
                if (lock_cnt_q != LW'(LOCK_CNT)) begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
                if (lock_cnt_d == LW'(LOCK_CNT)) begin
                    locked_d = 1'b1;
                end
                if (prev_idx_q == 3'd7) begin
                    wrap_d    = 1'b1;
                    rev_cnt_d = rev_cnt_q + REV_W'(1);
                end
            end else begin
                seq_err_d  = 1'b1;
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end
        end

        // A new error outranks a simultaneous clear request.
        if (seq_err_d) begin
            err_sticky_d = 1'b1;
        end else if (bus.err_clr) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            phase_oh_q   <= '0;
            phase_idx_q  <= '0;
            code_ok_q    <= 1'b0;
            seq_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            locked_q     <= 1'b0;
            wrap_q       <= 1'b0;
            rev_cnt_q    <= '0;
            prev_ok_q    <= 1'b0;
            prev_idx_q   <= '0;
            lock_cnt_q   <= '0;
        end else begin
            phase_oh_q   <= phase_oh_d;
            phase_idx_q  <= phase_idx_d;
            code_ok_q    <= code_ok_d;
            seq_err_q    <= seq_err_d;
            err_sticky_q <= err_sticky_d;
            locked_q     <= locked_d;
            wrap_q       <= wrap_d;
            rev_cnt_q    <= rev_cnt_d;
            prev_ok_q    <= prev_ok_d;
            prev_idx_q   <= prev_idx_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign bus.phase_oh   = phase_oh_q;
    assign bus.phase_idx  = phase_idx_q;
    assign bus.code_ok    = code_ok_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.locked     = locked_q;
    assign bus.wrap       = wrap_q;
    assign bus.rev_cnt    = rev_cnt_q;
endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench: directed scenarios plus random codes, two decoder instances
// (8-bit and 2-bit revolution counters) fed from one stimulus stream.
module tb_johnson_phase_decoder;
    localparam int LOCK = 8;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    johnson_phase_decoder_if #(.REV_W(8)) bus8 ();
    johnson_phase_decoder_if #(.REV_W(2)) bus2 ();

    johnson_phase_decoder #(.LOCK_CNT(LOCK), .REV_W(8)) dut8 (.clk(clk), .clr(clr), .bus(bus8));
    johnson_phase_decoder #(.LOCK_CNT(LOCK), .REV_W(2)) dut2 (.clk(clk), .clr(clr), .bus(bus2));

    assign bus2.cnt_in  = bus8.cnt_in;
    assign bus2.err_clr = bus8.err_clr;

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] idx;
        logic       ok;
        logic       err;
        logic       sticky;
        logic       locked;
        logic       wrap;
        logic [7:0] rev8;
        logic [1:0] rev2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: expressed as run lengths and plain counters.
    logic [3:0] codes [8] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
    bit  m_prev_ok;
    int  m_prev_idx;
    int  m_good_run;
    int  m_revs;
    bit  m_sticky;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lookup(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev_ok = 0; m_prev_idx = 0; m_good_run = 0; m_revs = 0; m_sticky = 0;
    endtask

    function automatic exp_t model_step(input logic [3:0] c, input bit eclr);
        exp_t e;
        int   k;
        e = '0;
        k = lookup(c);
        if (k < 0) begin
            e.err = 1; m_good_run = 0; m_prev_ok = 0;
        end else begin
            e.ok = 1; e.idx = 3'(k); e.oh = 8'(1 << k);
            if (m_prev_ok) begin
                if (k == (m_prev_idx + 1) % 8) begin
                    m_good_run++;
                    if (m_prev_idx == 7) begin e.wrap = 1; m_revs++; end
                end else begin
                    e.err = 1; m_good_run = 0;
                end
            end
            m_prev_ok = 1; m_prev_idx = k;
        end
        if (e.err) m_sticky = 1;
        else if (eclr) m_sticky = 0;
        e.sticky = m_sticky;
        e.locked = (m_good_run >= LOCK);
        e.rev8   = 8'(m_revs % 256);
        e.rev2   = 2'(m_revs % 4);
        return e;
    endfunction

    task automatic step(input logic [3:0] c, input bit eclr);
        @(negedge clk);
        clr          = 1'b1;
        bus8.cnt_in  = c;
        bus8.err_clr = eclr;
        exp_q.push_back(model_step(c, eclr));
    endtask

    task automatic walk(input int from_idx, input int n);
        for (int i = 0; i < n; i++) step(codes[(from_idx + i) % 8], 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_oh"},     int'(bus8.phase_oh),   0);
        check({tag, "_idx"},    int'(bus8.phase_idx),  0);
        check({tag, "_ok"},     int'(bus8.code_ok),    0);
        check({tag, "_err"},    int'(bus8.seq_err),    0);
        check({tag, "_sticky"}, int'(bus8.err_sticky), 0);
        check({tag, "_locked"}, int'(bus8.locked),     0);
        check({tag, "_wrap"},   int'(bus8.wrap),       0);
        check({tag, "_rev"},    int'(bus8.rev_cnt),    0);
        check({tag, "_rev2"},   int'(bus2.rev_cnt),    0);
    endtask

    // Monitor: every clocked edge out of reset produces one response to score.
    always @(posedge clk) begin
        if (clr) begin
            #1;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL no_expected: got output with empty scoreboard at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("phase_oh",   int'(bus8.phase_oh),   int'(e.oh));
                check("phase_idx",  int'(bus8.phase_idx),  int'(e.idx));
                check("code_ok",    int'(bus8.code_ok),    int'(e.ok));
                check("seq_err",    int'(bus8.seq_err),    int'(e.err));
                check("err_sticky", int'(bus8.err_sticky), int'(e.sticky));
                check("locked",     int'(bus8.locked),     int'(e.locked));
                check("wrap",       int'(bus8.wrap),       int'(e.wrap));
                check("rev_cnt",    int'(bus8.rev_cnt),    int'(e.rev8));
                check("rev_cnt_w2", int'(bus2.rev_cnt),    int'(e.rev2));
                check("err_and_wrap", int'(bus8.seq_err & bus8.wrap), 0);
                $display("edge t=%0t cnt=%h oh=%h idx=%0d ok=%b err=%b stk=%b lk=%b wrap=%b rev=%0d rev2=%0d",
                         $time, bus8.cnt_in, bus8.phase_oh, bus8.phase_idx, bus8.code_ok,
                         bus8.seq_err, bus8.err_sticky, bus8.locked, bus8.wrap,
                         bus8.rev_cnt, bus2.rev_cnt);
            end
        end
    end

    initial begin
        bus8.cnt_in  = 4'h0;
        bus8.err_clr = 1'b0;
        model_reset();
        #12;
        check_zero("reset");

        // Full legal sequence for 17 edges: lock at edge 9, wraps at 9 and 17.
        walk(0, 17);
        // Lock again then an illegal code, resume at 0xC, relock.
        walk(1, 10);
        step(4'h5, 1'b0);
        walk(2, 10);
        // Skip 0x8 -> 0xE.
        walk(0, 2);
        step(4'hE, 1'b0);
        walk(4, 9);
        // Hold 0xF, 0xF.
        walk(5, 7);
        step(4'hF, 1'b0);
        step(4'hF, 1'b0);
        // Bad step with err_clr, then a clean cycle with err_clr.
        step(4'hF, 1'b1);
        step(4'h7, 1'b1);
        walk(6, 3);
        // Mid-run reset at phase 5, asynchronous to the clock edge.
        walk(2, 4);
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        model_reset();
        check_zero("async_clr");
        @(negedge clk);
        step(4'h0, 1'b0);
        // Four more revolutions.
        walk(1, 32);

        // Randomised mix of good steps, holds, skips, reverses and illegal codes.
        for (int i = 0; i < 400; i++) begin
            int r, cur;
            logic [3:0] c;
            r   = int'($urandom_range(0, 99));
            cur = m_prev_ok ? m_prev_idx : 0;
            if (r < 70)      c = codes[(cur + 1) % 8];
            else if (r < 78) c = codes[cur];
            else if (r < 86) c = codes[(cur + 2 + int'($urandom_range(0, 5))) % 8];
            else             c = 4'($urandom_range(0, 15));
            step(c, ($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        bus8.err_clr = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
